// File: rtl/departure_sequencer.sv
// departure_sequencer
//   Queues takeoff requests from occupied gates and clears them one at a time
//   onto a free runway. Applies weather holds before clearance and a wake
//   separation interval after each takeoff. Runway encoding: 01 = runway 1,
//   10 = runway 2, 00 = no grant.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid, req_gate   takeoff request (gate 0 is dropped)
//   req_ready             FIFO has room (decoded from the registered count)
//   weather               1 = conditions optimum
//   emergency             landing emergency, freezes new departures
//   runway_busy           bit0 runway 1 occupied, bit1 runway 2 occupied
//   grant_valid/gate/runway  clearance offered to the FIFO head
//   grant_ack             pilot accepts clearance
//   takeoff_done          cleared aircraft airborne
//   timer_active/value    weather hold or separation countdown
//   queue_count           FIFO occupancy
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | waiting for a queued request, emergency clear
// S_WX_HOLD | weather hold countdown
// S_GRANT   | clearance offered (first cycle loads the grant outputs)
// S_ROLL    | aircraft committed, waiting for takeoff_done
// S_SEP     | wake separation countdown
module departure_sequencer #(
  parameter int QUEUE_DEPTH    = 4,
  parameter int WX_HOLD_CYCLES = 12,
  parameter int SEP_CYCLES     = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [2:0] req_gate,
  output logic       req_ready,
  input  logic       weather,
  input  logic       emergency,
  input  logic [1:0] runway_busy,
  output logic       grant_valid,
  output logic [2:0] grant_gate,
  output logic [1:0] grant_runway,
  input  logic       grant_ack,
  input  logic       takeoff_done,
  output logic       timer_active,
  output logic [3:0] timer_value,
  output logic [2:0] queue_count
);

  localparam int         PW      = $clog2(QUEUE_DEPTH);
  localparam logic [2:0] DEPTH_C = 3'(QUEUE_DEPTH);
  localparam logic [3:0] WX_C    = 4'(WX_HOLD_CYCLES);
  localparam logic [3:0] SEP_C   = 4'(SEP_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_WX_HOLD, S_GRANT, S_ROLL, S_SEP} state_t;

  state_t        state_q;
  logic [2:0]    mem_q [QUEUE_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0]    count_q, count_d;
  logic [1:0]    rwy_sel_q;
  logic          grant_valid_q;
  logic [2:0]    grant_gate_q;
  logic [1:0]    grant_runway_q;
  logic          timer_active_q;
  logic [3:0]    timer_q;
  logic          push, pop;

  assign req_ready = (count_q < DEPTH_C);
  assign push      = req_valid & req_ready & (req_gate != 3'd0);
  // Pop only once the clearance is actually visible; emergency overrides ack.
  assign pop       = (state_q == S_GRANT) & grant_valid_q & grant_ack & ~emergency;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 3'd1;
    else if (pop && !push) count_d = count_q - 3'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= req_gate;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      rwy_sel_q      <= 2'b00;
      grant_valid_q  <= 1'b0;
      grant_gate_q   <= 3'd0;
      grant_runway_q <= 2'b00;
      timer_active_q <= 1'b0;
      timer_q        <= 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (count_q != 3'd0 && !emergency) begin
            if (!weather) begin
              state_q        <= S_WX_HOLD;
              timer_q        <= WX_C;
              timer_active_q <= 1'b1;
            end else if (!runway_busy[0]) begin
              state_q   <= S_GRANT;
              rwy_sel_q <= 2'b01;
            end else if (!runway_busy[1]) begin
              state_q   <= S_GRANT;
              rwy_sel_q <= 2'b10;
            end
          end
        end
        S_WX_HOLD: begin
          if (emergency || timer_q == 4'd1) begin
            state_q        <= S_IDLE;
            timer_q        <= 4'd0;
            timer_active_q <= 1'b0;
          end else begin
            timer_q <= timer_q - 4'd1;
          end
        end
        S_GRANT: begin
          if (emergency) begin
            state_q        <= S_IDLE;
            grant_valid_q  <= 1'b0;
            grant_gate_q   <= 3'd0;
            grant_runway_q <= 2'b00;
          end else if (!grant_valid_q) begin
            // Head cannot change while in GRANT, so it is safe to sample once.
            grant_valid_q  <= 1'b1;
            grant_gate_q   <= mem_q[rd_ptr_q];
            grant_runway_q <= rwy_sel_q;
          end else if (grant_ack) begin
            state_q        <= S_ROLL;
            grant_valid_q  <= 1'b0;
            grant_gate_q   <= 3'd0;
            grant_runway_q <= 2'b00;
          end
        end
        S_ROLL: begin
          if (takeoff_done) begin
            state_q        <= S_SEP;
            timer_q        <= SEP_C;
            timer_active_q <= 1'b1;
          end
        end
        S_SEP: begin
          if (timer_q == 4'd1) begin
            state_q        <= S_IDLE;
            timer_q        <= 4'd0;
            timer_active_q <= 1'b0;
          end else begin
            timer_q <= timer_q - 4'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant_valid  = grant_valid_q;
  assign grant_gate   = grant_gate_q;
  assign grant_runway = grant_runway_q;
  assign timer_active = timer_active_q;
  assign timer_value  = timer_q;
  assign queue_count  = count_q;

endmodule

// File: tb/tb_departure_sequencer.sv
// Directed bench for departure_sequencer: expected values are hand-computed
// from the edge-by-edge timing of the block (grant two edges after a push,
// grant outputs cleared on the ack edge, timer counts N..1).
module tb_departure_sequencer;

  localparam int SEP = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic [2:0] req_gate;
  logic       req_ready;
  logic       weather;
  logic       emergency;
  logic [1:0] runway_busy;
  logic       grant_valid;
  logic [2:0] grant_gate;
  logic [1:0] grant_runway;
  logic       grant_ack;
  logic       takeoff_done;
  logic       timer_active;
  logic [3:0] timer_value;
  logic [2:0] queue_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  departure_sequencer #(
    .QUEUE_DEPTH(4), .WX_HOLD_CYCLES(12), .SEP_CYCLES(SEP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_gate(req_gate), .req_ready(req_ready),
    .weather(weather), .emergency(emergency), .runway_busy(runway_busy),
    .grant_valid(grant_valid), .grant_gate(grant_gate), .grant_runway(grant_runway),
    .grant_ack(grant_ack), .takeoff_done(takeoff_done),
    .timer_active(timer_active), .timer_value(timer_value), .queue_count(queue_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [2:0] g);
    req_valid = 1'b1;
    req_gate  = g;
    tick(1);
    req_valid = 1'b0;
    req_gate  = 3'd0;
  endtask

  // From IDLE with a queued request: FSM moves to GRANT on the next edge,
  // grant outputs appear on the one after.
  task automatic expect_grant(input logic [2:0] g, input logic [1:0] rwy);
    tick(1);
    check_eq("grant_setup_gv", grant_valid, 0);
    tick(1);
    check_eq("grant_gv", grant_valid, 1);
    check_eq("grant_gate", grant_gate, g);
    check_eq("grant_rwy", grant_runway, rwy);
  endtask

  // Ack (optionally with a same-edge push), takeoff, full separation, back in IDLE.
  task automatic fly(input logic [2:0] push_gate, input logic [2:0] exp_cnt);
    grant_ack = 1'b1;
    if (push_gate != 3'd0) begin
      req_valid = 1'b1;
      req_gate  = push_gate;
    end
    tick(1);
    grant_ack = 1'b0;
    req_valid = 1'b0;
    req_gate  = 3'd0;
    check_eq("ack_gv", grant_valid, 0);
    check_eq("ack_rwy", grant_runway, 0);
    check_eq("ack_cnt", queue_count, exp_cnt);
    takeoff_done = 1'b1;
    tick(1);
    takeoff_done = 1'b0;
    check_eq("sep_start_val", timer_value, SEP);
    check_eq("sep_start_act", timer_active, 1);
    tick(SEP - 1);
    check_eq("sep_last_val", timer_value, 1);
    tick(1);
    check_eq("sep_end_act", timer_active, 0);
    check_eq("sep_end_val", timer_value, 0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_gate = 3'd0; weather = 1'b1;
    emergency = 1'b0; runway_busy = 2'b00; grant_ack = 1'b0; takeoff_done = 1'b0;
    tick(2);
    check_eq("rst_ready", req_ready, 1);
    check_eq("rst_gv", grant_valid, 0);
    check_eq("rst_gate", grant_gate, 0);
    check_eq("rst_rwy", grant_runway, 0);
    check_eq("rst_tact", timer_active, 0);
    check_eq("rst_tval", timer_value, 0);
    check_eq("rst_cnt", queue_count, 0);
    rst_n = 1'b1;
    tick(1);

    // Basic flow, including full SEP countdown 15..1.
    push(3);
    check_eq("basic_cnt", queue_count, 1);
    check_eq("basic_gv_e", grant_valid, 0);
    expect_grant(3, 2'b01);
    grant_ack = 1'b1;
    tick(1);
    grant_ack = 1'b0;
    check_eq("basic_ack_cnt", queue_count, 0);
    check_eq("basic_ack_gv", grant_valid, 0);
    tick(2);
    check_eq("basic_roll_tact", timer_active, 0);
    takeoff_done = 1'b1;
    tick(1);
    takeoff_done = 1'b0;
    for (int k = 0; k < SEP; k++) begin
      check_eq("basic_sep_val", timer_value, SEP - k);
      if (k < SEP - 1) tick(1);
    end
    tick(1);
    check_eq("basic_idle_tact", timer_active, 0);
    check_eq("basic_idle_cnt", queue_count, 0);

    // Runway selection and grant stability.
    runway_busy = 2'b01;
    push(6);
    expect_grant(6, 2'b10);
    runway_busy = 2'b00;
    weather = 1'b0;
    tick(2);
    check_eq("stable_gv", grant_valid, 1);
    check_eq("stable_rwy", grant_runway, 2'b10);
    check_eq("stable_gate", grant_gate, 6);
    weather = 1'b1;
    fly(0, 0);
    runway_busy = 2'b11;
    push(7);
    tick(5);
    check_eq("busy_gv", grant_valid, 0);
    check_eq("busy_cnt", queue_count, 1);
    runway_busy = 2'b00;
    expect_grant(7, 2'b01);
    fly(0, 0);

    // Weather hold with re-hold.
    weather = 1'b0;
    push(2);
    tick(1);
    for (int k = 0; k < 12; k++) begin
      check_eq("wx_val", timer_value, 12 - k);
      check_eq("wx_act", timer_active, 1);
      if (k < 11) tick(1);
    end
    tick(1);
    check_eq("wx_eval_act", timer_active, 0);
    check_eq("wx_eval_val", timer_value, 0);
    tick(1);
    check_eq("wx_rehold_val", timer_value, 12);
    weather = 1'b1;
    tick(11);
    check_eq("wx_rehold_last", timer_value, 1);
    tick(1);
    check_eq("wx_end_act", timer_active, 0);
    expect_grant(2, 2'b01);
    fly(0, 0);

    // FIFO boundaries, gate 0 drop, order, push+pop same edge, pointer wrap.
    runway_busy = 2'b11;
    push(1);
    push(2);
    push(0);
    check_eq("gate0_cnt", queue_count, 2);
    check_eq("gate0_ready", req_ready, 1);
    push(4);
    push(5);
    check_eq("full_cnt", queue_count, 4);
    check_eq("full_ready", req_ready, 0);
    push(6);
    check_eq("over_cnt", queue_count, 4);
    runway_busy = 2'b00;
    expect_grant(1, 2'b01);
    fly(0, 3);
    expect_grant(2, 2'b01);
    fly(7, 3);
    expect_grant(4, 2'b01);
    fly(0, 2);
    expect_grant(5, 2'b01);
    fly(0, 1);
    expect_grant(7, 2'b01);
    fly(0, 0);

    // Emergency handling.
    push(4);
    expect_grant(4, 2'b01);
    emergency = 1'b1;
    tick(1);
    check_eq("emg_gv", grant_valid, 0);
    check_eq("emg_rwy", grant_runway, 0);
    check_eq("emg_cnt", queue_count, 1);
    tick(3);
    check_eq("emg_hold_gv", grant_valid, 0);
    emergency = 1'b0;
    expect_grant(4, 2'b01);
    grant_ack = 1'b1;
    emergency = 1'b1;
    tick(1);
    grant_ack = 1'b0;
    emergency = 1'b0;
    check_eq("ackemg_cnt", queue_count, 1);
    check_eq("ackemg_gv", grant_valid, 0);
    expect_grant(4, 2'b01);
    grant_ack = 1'b1;
    tick(1);
    grant_ack = 1'b0;
    check_eq("emg_pop_cnt", queue_count, 0);
    emergency = 1'b1;
    tick(2);
    takeoff_done = 1'b1;
    tick(1);
    takeoff_done = 1'b0;
    check_eq("emg_roll_sep", timer_value, SEP);
    tick(SEP - 1);
    check_eq("emg_sep_last", timer_value, 1);
    tick(1);
    check_eq("emg_sep_end", timer_active, 0);
    emergency = 1'b0;

    // Reset in the middle of SEP with two requests queued.
    req_valid = 1'b1; req_gate = 3'd1; tick(1);
    req_gate = 3'd2; tick(1);
    req_gate = 3'd3; tick(1);
    req_valid = 1'b0; req_gate = 3'd0;
    check_eq("pre_rst_gate", grant_gate, 1);
    check_eq("pre_rst_cnt", queue_count, 3);
    grant_ack = 1'b1; tick(1); grant_ack = 1'b0;
    takeoff_done = 1'b1; tick(1); takeoff_done = 1'b0;
    tick(3);
    check_eq("mid_sep_val", timer_value, SEP - 3);
    check_eq("mid_sep_cnt", queue_count, 2);
    rst_n = 1'b0;
    tick(1);
    check_eq("mrst_ready", req_ready, 1);
    check_eq("mrst_gv", grant_valid, 0);
    check_eq("mrst_gate", grant_gate, 0);
    check_eq("mrst_rwy", grant_runway, 0);
    check_eq("mrst_tact", timer_active, 0);
    check_eq("mrst_tval", timer_value, 0);
    check_eq("mrst_cnt", queue_count, 0);
    rst_n = 1'b1;
    tick(3);
    check_eq("post_rst_gv", grant_valid, 0);
    check_eq("post_rst_cnt", queue_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
